// File: rtl/seq_scan_pkg.sv
// rtl/seq_scan_pkg.sv - shared state encodings and match pattern for the 1010 scan controller
package seq_scan_pkg;

  // Controller phases: take a word, shift it through the detector, let the last bit settle, present result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RESP  = 2'd3
  } ctrl_state_e;

  // Detector progress through the pattern; DET_E means a full match was just seen
  typedef enum logic [2:0] {
    DET_A = 3'd0,
    DET_B = 3'd1,
    DET_C = 3'd2,
    DET_D = 3'd3,
    DET_E = 3'd4
  } det_state_e;

  // Pattern bits, first-received bit in [3]
  localparam logic [3:0] PATTERN_1010 = 4'b1010;

endpackage

// File: rtl/seq_1010_det.sv
// rtl/seq_1010_det.sv - non-overlapping Moore detector for the serial pattern 1010
module seq_1010_det
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic hit
);

  det_state_e state_q, state_d;

  // Next state: clear wins over advance; with en low the state holds
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_A;
    end else if (en) begin
      unique case (state_q)
        DET_A:   state_d = (din == PATTERN_1010[3]) ? DET_B : DET_A;
        DET_B:   state_d = (din == PATTERN_1010[2]) ? DET_C : DET_B;
        DET_C:   state_d = (din == PATTERN_1010[1]) ? DET_D : DET_A;
        DET_D:   state_d = (din == PATTERN_1010[0]) ? DET_E : DET_B;
        // After a match nothing is reused: a 1 may start a new pattern, a 0 cannot
        DET_E:   state_d = (din == PATTERN_1010[3]) ? DET_B : DET_A;
        default: state_d = DET_A;
      endcase
    end
  end

  // Detector state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DET_A;
    end else begin
      state_q <= state_d;
    end
  end

  assign hit = (state_q == DET_E);

endmodule

// File: rtl/seq_1010_scan_ctrl.sv
// rtl/seq_1010_scan_ctrl.sv - word-serial 1010 match counter; define SCAN_CARRY_EN to carry detector state across words
module seq_1010_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_hits,
  output logic              out_any,
  input  logic              out_ready,
  output logic [15:0]       total_hits
);

  localparam int              BC_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};

  ctrl_state_e       state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [15:0]       total_q, total_d;
  logic [CNT_W-1:0]  out_hits_q, out_hits_d;
  logic              out_any_q, out_any_d;

  logic accept;
  logic det_en;
  logic det_din;
  logic det_clr;
  logic det_hit;
  logic count_ev;

  // In the first shift cycle the detector output still reflects the previous
  // word (already counted in its flush), so only later shift cycles count
  assign count_ev = det_hit &&
                    (((state_q == ST_SHIFT) && (bit_cnt_q != '0)) || (state_q == ST_FLUSH));

`ifdef SCAN_CARRY_EN
  // Stream mode: detector runs on continuously, matches may straddle words
  assign det_clr = 1'b0;
`else
  // Word mode: every accepted word starts from a fresh detector
  assign det_clr = accept;
`endif

  // Controller next-state, datapath updates and handshake outputs
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    total_d    = total_q;
    out_hits_d = out_hits_q;
    out_any_d  = out_any_q;
    accept     = 1'b0;
    det_en     = 1'b0;
    det_din    = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    if (count_ev) begin
      if (hit_cnt_q != HIT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      if (total_q != 16'hFFFF)  total_d   = total_q + 16'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          shreg_d   = in_word;
          bit_cnt_d = '0;
          hit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_en    = 1'b1;
        det_din   = shreg_q[WORD_W-1];
        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == LAST_BIT) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Last bit's match becomes visible here; latch the final count for the response
        out_hits_d = hit_cnt_d;
        out_any_d  = (hit_cnt_d != '0);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      total_q    <= '0;
      out_hits_q <= '0;
      out_any_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      total_q    <= total_d;
      out_hits_q <= out_hits_d;
      out_any_q  <= out_any_d;
    end
  end

  seq_1010_det u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (det_en),
    .clr   (det_clr),
    .din   (det_din),
    .hit   (det_hit)
  );

  assign out_hits   = out_hits_q;
  assign out_any    = out_any_q;
  assign total_hits = total_q;

endmodule

// File: tb/tb_seq_1010_scan_ctrl.sv
// tb/tb_seq_1010_scan_ctrl.sv - scoreboard bench for seq_1010_scan_ctrl (WORD_W=8, CNT_W=4)
module tb_seq_1010_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_word;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_hits;
  logic       out_any;
  logic       out_ready;
  logic [15:0] total_hits;

  seq_1010_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_hits   (out_hits),
    .out_any    (out_any),
    .out_ready  (out_ready),
    .total_hits (total_hits)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] tx_q[$];
  int         exp_q[$];
  int         exp_total = 0;
  logic [3:0] m_win = 4'd0;
  int         m_since = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Greedy leftmost non-overlapping substring count over the bit stream
  function automatic int model_word(input logic [7:0] w);
    int n = 0;
`ifndef SCAN_CARRY_EN
    m_win   = 4'd0;
    m_since = 0;
`endif
    for (int i = 7; i >= 0; i--) begin
      m_win = {m_win[2:0], w[i]};
      m_since++;
      if (m_since >= 4 && m_win == 4'b1010) begin
        n++;
        m_since = 0;
      end
    end
    return n;
  endfunction

  function automatic void model_reset();
    m_win     = 4'd0;
    m_since   = 0;
    exp_total = 0;
    exp_q.delete();
  endfunction

  // Send everything in tx_q with out_ready held high, scoring every response
  task automatic drain(input int budget, input bit chk_lat, input bit chk_tp);
    int  cyc = 0;
    int  prev_acc = -1;
    bit  seen = 1'b0;
    int  lat_acc[$];
    int  e;
    int  n;
    logic [7:0] w;
    out_ready = 1'b1;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (chk_lat && lat_acc.size() > 0) chk("latency", 32'(cyc - lat_acc[0]), 32'd10);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_hits", 32'(out_hits), 32'(e));
          chk("out_any", 32'(out_any), 32'(e != 0));
        end
        if (lat_acc.size() > 0) void'(lat_acc.pop_front());
        seen = 1'b0;
      end
      if (tx_q.size() > 0) begin
        in_valid = 1'b1;
        in_word  = tx_q[0];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        w = tx_q.pop_front();
        n = model_word(w);
        exp_q.push_back(n);
        exp_total = (exp_total + n > 65535) ? 65535 : exp_total + n;
        lat_acc.push_back(cyc);
        if (chk_tp && prev_acc >= 0) chk("throughput", 32'(cyc - prev_acc), 32'd11);
        prev_acc = cyc;
      end
    end
    if (cyc >= budget) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("out_valid_after_drain", 32'(out_valid), 32'd0);
    chk("total_hits", 32'(total_hits), 32'(exp_total));
  endtask

  initial begin
    int  n;
    int  wait_cyc;
    bit  stray;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_hits", 32'(out_hits), 32'd0);
    chk("rst_out_any", 32'(out_any), 32'd0);
    chk("rst_total", 32'(total_hits), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single words: two matches, none, one
    tx_q.push_back(8'hAA);
    drain(40, 1'b1, 1'b0);
    tx_q.push_back(8'hF0);
    tx_q.push_back(8'hA5);
    drain(60, 1'b1, 1'b0);

    // Word-boundary patterns (expectations follow the build's carry mode)
    tx_q.push_back(8'h0A);
    tx_q.push_back(8'h0A);
    tx_q.push_back(8'h05);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h00);
    drain(120, 1'b0, 1'b1);

    // Back-to-back mix
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'h0D);
    tx_q.push_back(8'h50);
    drain(100, 1'b1, 1'b1);

    // Consumer stall: response must hold and new words must be ignored
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_word   = 8'hA5;
    chk("stall_in_ready_idle", 32'(in_ready), 32'd1);
    n = model_word(8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("stall_reach_resp", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_word  = 8'hAA;
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_hits", 32'(out_hits), 32'(n));
      chk("stall_out_any", 32'(out_any), 32'(n != 0));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_released", 32'(out_valid), 32'd0);
    chk("stall_hold_hits", 32'(out_hits), 32'(n));
    exp_total = exp_total + n;
    stray = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    chk("stall_ignored_word", 32'(stray), 32'd0);
    chk("stall_total", 32'(total_hits), 32'(exp_total));

    // Reset while shifting bit 4 of 8'hAA: word discarded, everything cleared
    in_valid = 1'b1;
    in_word  = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_hits", 32'(out_hits), 32'd0);
    chk("midrst_out_any", 32'(out_any), 32'd0);
    chk("midrst_total", 32'(total_hits), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    chk("midrst_no_result", 32'(stray), 32'd0);
    chk("midrst_total_after", 32'(total_hits), 32'd0);

    // Long run: 300 x 8'hAA
    for (int i = 0; i < 300; i++) tx_q.push_back(8'hAA);
    drain(4000, 1'b0, 1'b1);
    chk("total_600", 32'(total_hits), 32'd600);

    // Saturation: preset the running total near the top, then keep scanning
    @(negedge clk);
    force dut.total_q = 16'hFFF0;
    @(negedge clk);
    release dut.total_q;
    exp_total = 16'hFFF0;
    chk("preset_total", 32'(total_hits), 32'hFFF0);
    for (int i = 0; i < 12; i++) tx_q.push_back(8'hAA);
    drain(200, 1'b0, 1'b0);
    chk("total_saturated", 32'(total_hits), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
